traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
Phase sequencer for the intersection traffic-light datapath.
- Main road rests green. Side-road vehicle demand (SW) or a latched pedestrian request moves it through yellow and all-red to a walk phase and/or side-road green, then back to main green.
- Phase dwell times are counted in `tick` enables from an external prescaler, so sim and board differ only in tick rate.
- The block drives the lamp outputs directly.

Parameters:
- GREEN_MIN, 4: minimum green dwell in ticks, both roads
- GREEN_MAX, 10: maximum side-road green dwell in ticks
- YELLOW_T, 2: yellow dwell in ticks
- ALLRED_T, 1: all-red clearance dwell in ticks
- WALK_T, 3: pedestrian walk dwell in ticks
- CNT_W, 8: phase timer width; every dwell parameter must be ≤ 2^CNT_W−1

Ports:
- CLK, input, 1: system clock, rising edge
- reset, input, 1: asynchronous, active-high; returns block to reset state immediately
- tick, input, 1: timing enable; timer advances only on cycles with tick=1
- SW, input, 1: side-road vehicle sensor, level, synchronous to CLK
- ped_req, input, 1: pedestrian button, any-length pulse, synchronous
- main_lights, output, 3: {red, yellow, green} for main road
- side_lights, output, 3: {red, yellow, green} for side road
- walk, output, 1: pedestrian walk lamp
- ped_pending, output, 1: pedestrian request latched, not yet served
- state_o, output, 3: current state encoding, for debug/verification

Behaviour:
- States and encoding: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED1=2, WALK=3, SIDE_GREEN=4, SIDE_YELLOW=5, ALL_RED2=6. Code 7 is illegal: all lamps red, next state ALL_RED2.
- Reset values: state MAIN_GREEN; timer 0; ped_pending 0; main_lights=001; side_lights=100; walk=0.
- Outputs are Moore-decoded from the state register and change in the same cycle as the state.
  - MAIN_GREEN: main 001, side 100
  - MAIN_YELLOW: main 010, side 100
  - SIDE_GREEN: main 100, side 001
  - SIDE_YELLOW: main 100, side 010
  - ALL_RED1, ALL_RED2, WALK: both 100
  - walk=1 only in WALK
- Timer rules:
  - Cleared to 0 on every state transition.
  - Otherwise increments on tick=1, saturating at 2^CNT_W−1.
  - "Dwell N expires" means tick=1 and timer==N−1 in the same cycle. With tick held high, a state therefore lasts exactly N cycles.
- Transitions, evaluated only on tick=1 cycles:
  - MAIN_GREEN→MAIN_YELLOW when timer≥GREEN_MIN−1 and (SW or ped_pending). Without demand, stays indefinitely.
  - MAIN_YELLOW→ALL_RED1 when YELLOW_T expires.
  - ALL_RED1→WALK if ped_pending; else →SIDE_GREEN. Both on ALLRED_T expiry.
  - WALK→SIDE_GREEN if SW; else →ALL_RED2. Both on WALK_T expiry.
  - SIDE_GREEN→SIDE_YELLOW when (timer≥GREEN_MIN−1 and !SW) or timer==GREEN_MAX−1.
  - SIDE_YELLOW→ALL_RED2 when YELLOW_T expires.
  - ALL_RED2→MAIN_GREEN when ALLRED_T expires.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the clock edge entering WALK. Clear has priority over a simultaneous set.
  - ped_req while in WALK is ignored.
  - ped_req in any other state stays latched until the next WALK.
- SW and ped_req are sampled every cycle; only their value on tick cycles affects transitions.
- Reset asserted mid-phase: all state forced to reset values asynchronously. A pending pedestrian request is discarded.

Test Plan:
- Idle: reset, SW=0, ped_req=0, tick=1 for 30 cycles → state_o=0, main_lights=001, side_lights=100 every cycle.
- Side demand: after reset, SW=1 held, tick=1. Required sequence:
  - state 0 for 4 cycles, 1 for 2, 2 for 1
  - 4 for 10 (GREEN_MAX cap), 5 for 2, 6 for 1
  - back to 0 for 4, then 1
- Pedestrian only: ped_req pulse at cycle 5, SW=0, tick=1.
  - ped_pending=1 from cycle 6.
  - Sequence 0→1 (2 cycles)→2 (1)→3, with walk=1 for exactly 3 cycles and ped_pending=0 on WALK entry.
  - Then 6 (1)→0; stays 0.
- Early side release: SW=1 until 2 cycles into SIDE_GREEN, then 0 → SIDE_GREEN lasts exactly 4 cycles, then SIDE_YELLOW.
- Tick gating: tick=1 every 4th cycle, SW=1 → every dwell is 4× its tick count (MAIN_YELLOW 8 cycles, ALL_RED1 4), aligned to tick edges.
- Reset mid-operation: assert reset for 1 cycle during SIDE_GREEN with ped_pending=1 → outputs reach main 001, side 100, walk 0, ped_pending 0 before the next CLK edge; the sequence restarts from MAIN_GREEN.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer. Main road rests green. Side-road demand or a
// latched pedestrian request cycles it through the clearance phases, then
// through walk and/or side green, and back to main green. All dwells are
// counted in tick enables. The lamp outputs are decoded from the state register.
//
// state       | code | meaning
// ------------+------+----------------------------------------------
// MAIN_GREEN  |  0   | main road green, side red (rest state)
// MAIN_YELLOW |  1   | main road yellow, side red
// ALL_RED1    |  2   | clearance before walk / side green
// WALK        |  3   | pedestrian walk lamp on, all vehicles red
// SIDE_GREEN  |  4   | side road green, main red
// SIDE_YELLOW |  5   | side road yellow, main red
// ALL_RED2    |  6   | clearance before returning to main green
// (illegal)   |  7   | all red, recovers through ALL_RED2
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick,
  input  logic       SW,
  input  logic       ped_req,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_ALL_RED1    = 3'd2;
  localparam logic [2:0] S_WALK        = 3'd3;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd4;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd5;
  localparam logic [2:0] S_ALL_RED2    = 3'd6;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Terminal counts: a dwell of N ticks expires when the timer reads N-1.
  localparam logic [CNT_W-1:0] GMIN_TC   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_TC   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_TC = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_TC = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_TC   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_q, ped_d;
  logic             enter_walk;

  // Next-phase selection; a phase can only end on a tick cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_GREEN:
        if (tick && (timer_q >= GMIN_TC) && (SW || ped_q)) state_d = S_MAIN_YELLOW;
      S_MAIN_YELLOW:
        if (tick && (timer_q == YELLOW_TC)) state_d = S_ALL_RED1;
      S_ALL_RED1:
        if (tick && (timer_q == ALLRED_TC)) state_d = ped_q ? S_WALK : S_SIDE_GREEN;
      S_WALK:
        if (tick && (timer_q == WALK_TC)) state_d = SW ? S_SIDE_GREEN : S_ALL_RED2;
      S_SIDE_GREEN:
        if (tick && (((timer_q >= GMIN_TC) && !SW) || (timer_q == GMAX_TC)))
          state_d = S_SIDE_YELLOW;
      S_SIDE_YELLOW:
        if (tick && (timer_q == YELLOW_TC)) state_d = S_ALL_RED2;
      S_ALL_RED2:
        if (tick && (timer_q == ALLRED_TC)) state_d = S_MAIN_GREEN;
      default:
        state_d = S_ALL_RED2;
    endcase
  end

  // Phase timer restarts on every phase change and saturates instead of wrapping,
  // so a long idle main green never re-arms the minimum-green check.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (tick && (timer_q != TIMER_MAX))
      timer_d = timer_q + CNT_W'(1);
  end

  // Pedestrian latch: serving (entering WALK) wins over a same-cycle press,
  // and presses during WALK are already being served so they are dropped.
  always_comb begin
    enter_walk = (state_d == S_WALK) && (state_q != S_WALK);
    ped_d      = ped_q;
    if (enter_walk)
      ped_d = 1'b0;
    else if (ped_req && (state_q != S_WALK))
      ped_d = 1'b1;
  end

  // State, timer and pedestrian latch registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_MAIN_GREEN;
      timer_q <= '0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
    end
  end

  // Moore lamp decode; anything unrecognised shows all red.
  always_comb begin
    main_lights = LAMP_RED;
    side_lights = LAMP_RED;
    walk        = 1'b0;
    case (state_q)
      S_MAIN_GREEN:  main_lights = LAMP_GREEN;
      S_MAIN_YELLOW: main_lights = LAMP_YELLOW;
      S_SIDE_GREEN:  side_lights = LAMP_GREEN;
      S_SIDE_YELLOW: side_lights = LAMP_YELLOW;
      S_WALK:        walk        = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = ped_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler. Expectations come from a
// phase/elapsed-tick reference model. A monitor process compares them after every clock edge.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 4;
  localparam int GREEN_MAX = 10;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 3;
  localparam int CNT_W     = 8;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       SW = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_lights, side_lights, state_o;
  logic       walk, ped_pending;

  traffic_phase_scheduler #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .reset(reset), .tick(tick), .SW(SW), .ped_req(ped_req),
    .main_lights(main_lights), .side_lights(side_lights), .walk(walk),
    .ped_pending(ped_pending), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int st;
    int ml;
    int sl;
    int wk;
    int pp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Lamp codes per phase: red=4, yellow=2, green=1.
  int main_tab [7] = '{1, 2, 4, 4, 4, 4, 4};
  int side_tab [7] = '{4, 4, 4, 4, 1, 2, 4};

  // Reference model: phase number, ticks spent in phase, pedestrian latch.
  int m_ph   = 0;
  int m_el   = 0;
  int m_pend = 0;

  int st_log[$];
  int pp_log[$];
  int wk_log[$];
  int rs_st[$];
  int rs_len[$];
  int ex_st[$];
  int ex_len[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(bit tk, bit sw, bit pr);
    int nph = m_ph;
    int done = m_el + 1;
    if (tk) begin
      case (m_ph)
        0: if (done >= GREEN_MIN && (sw || m_pend != 0)) nph = 1;
        1: if (done == YELLOW_T) nph = 2;
        2: if (done == ALLRED_T) nph = (m_pend != 0) ? 3 : 4;
        3: if (done == WALK_T) nph = sw ? 4 : 6;
        4: if ((done >= GREEN_MIN && !sw) || done == GREEN_MAX) nph = 5;
        5: if (done == YELLOW_T) nph = 6;
        default: if (done == ALLRED_T) nph = 0;
      endcase
    end
    if (nph == 3 && m_ph != 3) m_pend = 0;
    else if (pr && m_ph != 3) m_pend = 1;
    if (nph != m_ph) m_el = 0;
    else if (tk) m_el = m_el + 1;
    m_ph = nph;
  endtask

  task automatic push_expect();
    exp_t e;
    e.st = m_ph;
    e.ml = main_tab[m_ph];
    e.sl = side_tab[m_ph];
    e.wk = (m_ph == 3) ? 1 : 0;
    e.pp = m_pend;
    exp_q.push_back(e);
  endtask

  // One clock cycle: log what the DUT shows, drive inputs for the next edge,
  // advance the model and queue the response expected after that edge.
  task automatic cycle(bit r, bit tk, bit sw, bit pr);
    @(negedge CLK);
    st_log.push_back(int'(state_o));
    pp_log.push_back(int'(ped_pending));
    wk_log.push_back(int'(walk));
    reset = r; tick = tk; SW = sw; ped_req = pr;
    if (r) begin
      m_ph = 0; m_el = 0; m_pend = 0;
      #1;
      chk("async_rst_state", int'(state_o), 0);
      chk("async_rst_main", int'(main_lights), 1);
      chk("async_rst_side", int'(side_lights), 4);
      chk("async_rst_walk", int'(walk), 0);
      chk("async_rst_ped", int'(ped_pending), 0);
    end else begin
      model_step(tk, sw, pr);
    end
    push_expect();
  endtask

  task automatic clear_logs();
    st_log.delete(); pp_log.delete(); wk_log.delete();
    ex_st.delete(); ex_len.delete();
  endtask

  task automatic want(int s, int l);
    ex_st.push_back(s);
    ex_len.push_back(l);
  endtask

  // Compare run-length encoding of the logged states with the wanted runs;
  // a wanted length of -1 only checks that the phase is reached.
  task automatic check_runs(string nm);
    rs_st.delete(); rs_len.delete();
    foreach (st_log[i]) begin
      if (i == 0 || st_log[i] != st_log[i-1]) begin
        rs_st.push_back(st_log[i]);
        rs_len.push_back(1);
      end else begin
        rs_len[rs_len.size()-1]++;
      end
    end
    if (rs_st.size() < ex_st.size()) begin
      chk($sformatf("%s_nruns", nm), rs_st.size(), ex_st.size());
    end else begin
      foreach (ex_st[i]) begin
        chk($sformatf("%s_run%0d_state", nm, i), rs_st[i], ex_st[i]);
        if (ex_len[i] >= 0) chk($sformatf("%s_run%0d_len", nm, i), rs_len[i], ex_len[i]);
      end
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  always @(posedge CLK) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_state", int'(state_o), e.st);
      chk("sb_main", int'(main_lights), e.ml);
      chk("sb_side", int'(side_lights), e.sl);
      chk("sb_walk", int'(walk), e.wk);
      chk("sb_ped", int'(ped_pending), e.pp);
    end
  end

  initial begin
    int found;
    int nwalk;

    // Idle: no demand, main green forever.
    cycle(1, 0, 0, 0);
    clear_logs();
    repeat (30) cycle(0, 1, 0, 0);
    want(0, -1);
    check_runs("idle");
    chk("idle_len", st_log.size(), 30);
    chk("idle_runs", rs_st.size(), 1);

    // Side demand held: side green capped by GREEN_MAX.
    cycle(1, 0, 0, 0);
    clear_logs();
    repeat (27) cycle(0, 1, 1, 0);
    want(0, 4); want(1, 2); want(2, 1); want(4, 10); want(5, 2); want(6, 1);
    want(0, 4); want(1, -1);
    check_runs("side");

    // Pedestrian only: one press at cycle 5.
    cycle(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 22; i++) cycle(0, 1, 0, (i == 5));
    want(0, 7); want(1, 2); want(2, 1); want(3, 3); want(6, 1); want(0, -1);
    check_runs("ped");
    chk("ped_pend_c5", pp_log[5], 0);
    chk("ped_pend_c6", pp_log[6], 1);
    chk("ped_pend_walk_entry", pp_log[10], 0);
    nwalk = 0;
    foreach (wk_log[i]) nwalk += wk_log[i];
    chk("ped_walk_cycles", nwalk, 3);

    // Early side release: SW drops two cycles into side green.
    cycle(1, 0, 0, 0);
    clear_logs();
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cycle(0, 1, 1, 0);
      if (state_o == 3'd4) found = 1;
    end
    chk("early_reach_side", found, 1);
    cycle(0, 1, 1, 0);
    repeat (8) cycle(0, 1, 0, 0);
    want(0, 4); want(1, 2); want(2, 1); want(4, 4); want(5, 2); want(6, 1);
    check_runs("early");

    // Tick gating: one tick every 4th cycle.
    cycle(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 70; i++) cycle(0, (i % 4 == 3), 1, 0);
    want(0, 16); want(1, 8); want(2, 4); want(4, -1);
    check_runs("gated");

    // Reset during side green with a pedestrian request latched.
    cycle(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cycle(0, 1, 1, 0);
      if (state_o == 3'd4) found = 1;
    end
    chk("midrst_reach_side", found, 1);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 0);
    chk("midrst_ped_latched", int'(ped_pending), 1);
    chk("midrst_in_side", int'(state_o), 4);
    cycle(1, 1, 1, 0);
    clear_logs();
    repeat (12) cycle(0, 1, 1, 0);
    want(0, 4); want(1, 2); want(2, 1); want(4, -1);
    check_runs("midrst");

    // Randomised traffic against the model.
    cycle(1, 0, 0, 0);
    begin
      bit sw_r = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 9) == 0) sw_r = ~sw_r;
        cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), sw_r,
              ($urandom_range(0, 19) == 0));
      end
    end

    cycle(0, 0, 0, 0);
    @(negedge CLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
